// File: rtl/fxp_pkg.sv
// Shared definitions for the fixed-point ALU pipeline: op encoding and
// elaboration-time helpers.
package fxp_pkg;

    typedef logic [1:0] op_t;

    localparam op_t OP_ADD  = 2'b00;
    localparam op_t OP_SUB  = 2'b01;
    localparam op_t OP_MUL  = 2'b10;
    localparam op_t OP_PASS = 2'b11;

    function automatic int unsigned fxp_max(input int unsigned x, input int unsigned y);
        return (x > y) ? x : y;
    endfunction

endpackage

// File: rtl/fxp_round_sat.sv
// Combinational format conversion: round half up (or exact left shift) from
// IN_FRAC to OUT_FRAC fractional bits, then clip to OUT_W signed bits.
module fxp_round_sat
    import fxp_pkg::*;
#(
    parameter int unsigned IN_W     = 34,
    parameter int unsigned IN_FRAC  = 26,
    parameter int unsigned OUT_W    = 18,
    parameter int unsigned OUT_FRAC = 14
) (
    input  logic signed [IN_W-1:0]  x,
    output logic signed [OUT_W-1:0] y,
    output logic                    sat
);

    localparam int unsigned RSH = (IN_FRAC > OUT_FRAC) ? IN_FRAC - OUT_FRAC : 0;
    localparam int unsigned LSH = (OUT_FRAC > IN_FRAC) ? OUT_FRAC - IN_FRAC : 0;
    // Wide enough for the rounding carry, the left shift and both clip bounds.
    localparam int unsigned EW  = fxp_max(IN_W + 1 + LSH, OUT_W + 1);

    localparam logic signed [EW-1:0] Y_MAX = {{(EW - OUT_W + 1){1'b0}}, {(OUT_W - 1){1'b1}}};
    localparam logic signed [EW-1:0] Y_MIN = {{(EW - OUT_W + 1){1'b1}}, {(OUT_W - 1){1'b0}}};

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;

    assign ext = EW'(x);

    if (RSH > 0) begin : g_round
        localparam logic signed [EW-1:0] HALF = EW'(1) << (RSH - 1);
        assign rnd = (ext + HALF) >>> RSH;
    end else begin : g_shift
        assign rnd = ext <<< LSH;
    end

    always_comb begin
        sat = 1'b0;
        y   = rnd[OUT_W-1:0];
        if (rnd > Y_MAX) begin
            sat = 1'b1;
            y   = {1'b0, {(OUT_W - 1){1'b1}}};
        end else if (rnd < Y_MIN) begin
            sat = 1'b1;
            y   = {1'b1, {(OUT_W - 1){1'b0}}};
        end
    end

endmodule

// File: rtl/fxp_alu_pipe.sv
// Three-stage fixed-point add/sub/mul/pass unit with independent operand Q
// formats, round-half-up and saturation to the output format, and a
// valid/ready stream interface.
module fxp_alu_pipe
    import fxp_pkg::*;
#(
    parameter int unsigned A_W    = 17,
    parameter int unsigned A_FRAC = 14,
    parameter int unsigned B_W    = 17,
    parameter int unsigned B_FRAC = 12,
    parameter int unsigned Y_W    = 18,
    parameter int unsigned Y_FRAC = 14,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  op_t                   op,
    input  logic signed [A_W-1:0] a,
    input  logic signed [B_W-1:0] b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic signed [Y_W-1:0] y,
    output logic                  sat,
    input  logic                  sat_clr,
    output logic [CNT_W-1:0]      sat_count
);

    localparam int unsigned F      = fxp_max(A_FRAC, B_FRAC);
    localparam int unsigned AL_W   = fxp_max(A_W - A_FRAC, B_W - B_FRAC) + F;
    localparam int unsigned SUM_W  = AL_W + 1;
    localparam int unsigned P_W    = A_W + B_W;
    localparam int unsigned P_FRAC = A_FRAC + B_FRAC;
    // Common S2 format: product's fraction, enough integer bits for either path.
    localparam int unsigned R_W    = fxp_max(SUM_W - F, P_W - P_FRAC) + P_FRAC;

    if (Y_FRAC > A_FRAC + B_FRAC || A_W < 2 || B_W < 2 || Y_W < 2 || CNT_W < 2)
    begin : g_param_check
        $error("fxp_alu_pipe: illegal parameter combination");
    end

    logic                    advance;
    logic                    s1_valid;
    op_t                     s1_op;
    logic signed [A_W-1:0]   s1_a;
    logic signed [B_W-1:0]   s1_b;
    logic signed [AL_W-1:0]  s1_aa;
    logic signed [AL_W-1:0]  s1_ba;
    logic                    s2_valid;
    logic signed [R_W-1:0]   s2_r;
    logic signed [SUM_W-1:0] sum;
    logic signed [P_W-1:0]   prod;
    logic signed [R_W-1:0]   r_d;
    logic signed [Y_W-1:0]   rs_y;
    logic                    rs_sat;

    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    always_comb begin
        sum = '0;
        case (s1_op)
            OP_ADD:  sum = SUM_W'(s1_aa) + SUM_W'(s1_ba);
            OP_SUB:  sum = SUM_W'(s1_aa) - SUM_W'(s1_ba);
            default: sum = SUM_W'(s1_aa);
        endcase
        prod = P_W'(s1_a) * P_W'(s1_b);
        if (s1_op == OP_MUL) begin
            r_d = R_W'(prod);
        end else begin
            r_d = R_W'(sum) <<< (P_FRAC - F);
        end
    end

    fxp_round_sat #(
        .IN_W     (R_W),
        .IN_FRAC  (P_FRAC),
        .OUT_W    (Y_W),
        .OUT_FRAC (Y_FRAC)
    ) u_round_sat (
        .x   (s2_r),
        .y   (rs_y),
        .sat (rs_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_op     <= OP_ADD;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_aa     <= '0;
            s1_ba     <= '0;
            s2_valid  <= 1'b0;
            s2_r      <= '0;
            out_valid <= 1'b0;
            y         <= '0;
            sat       <= 1'b0;
        end else if (advance) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_op <= op;
                s1_a  <= a;
                s1_b  <= b;
                s1_aa <= AL_W'(a) <<< (F - A_FRAC);
                s1_ba <= AL_W'(b) <<< (F - B_FRAC);
            end
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_r <= r_d;
            end
            out_valid <= s2_valid;
            if (s2_valid) begin
                y   <= rs_y;
                sat <= rs_sat;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sat_count <= '0;
        end else if (sat_clr) begin
            sat_count <= '0;
        end else if (out_valid && out_ready && sat && (sat_count != '1)) begin
            sat_count <= sat_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fxp_alu_pipe.sv
// Bench for fxp_alu_pipe: literal directed cases plus a randomized
// backpressured stream scored against an arithmetic reference model.
module tb_fxp_alu_pipe;

    localparam longint YMAX = 131071;
    localparam longint YMIN = -131072;

    typedef struct packed {
        logic               sat;
        logic signed [17:0] y;
    } res_t;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               out_ready = 1'b0;
    logic               sat_clr = 1'b0;
    logic [1:0]         op = 2'b00;
    logic signed [16:0] a = '0;
    logic signed [16:0] b = '0;
    logic               in_ready;
    logic               out_valid;
    logic               sat;
    logic signed [17:0] y;
    logic [15:0]        sat_count;

    int n_tests = 0;
    int n_fail = 0;
    int n_acc = 0;
    int n_deliv = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int deliv_cyc = 0;
    logic signed [17:0] last_y = '0;
    logic               last_sat = 1'b0;
    res_t               sb[$];

    fxp_alu_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .sat       (sat),
        .sat_clr   (sat_clr),
        .sat_count (sat_count)
    );

    always #5 clk = ~clk;

    // Values are taken in units of 2^-26, then rounded to 2^-14 and clipped.
    function automatic res_t model(input logic [1:0] o, input longint av, input longint bv);
        longint v;
        longint r;
        res_t   res;
        case (o)
            2'b00:   v = av * 4096 + bv * 16384;
            2'b01:   v = av * 4096 - bv * 16384;
            2'b10:   v = av * bv;
            default: v = av * 4096;
        endcase
        r = (v + 2048) >>> 12;
        res.sat = 1'b0;
        if (r > YMAX) begin
            r = YMAX;
            res.sat = 1'b1;
        end else if (r < YMIN) begin
            r = YMIN;
            res.sat = 1'b1;
        end
        res.y = r[17:0];
        return res;
    endfunction

    task automatic check(input string name, input longint got, input longint exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Compare process: scoreboard on delivery, stability while stalled.
    initial begin
        res_t e;
        logic prev_stall;
        logic signed [17:0] prev_y;
        logic prev_sat;
        prev_stall = 1'b0;
        prev_y = '0;
        prev_sat = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sb.delete();
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    check("stall_y", y, prev_y);
                    check("stall_sat", sat, prev_sat);
                    check("stall_valid", out_valid, 1);
                end
                if (out_valid && out_ready) begin
                    n_deliv++;
                    deliv_cyc = cyc;
                    last_y = y;
                    last_sat = sat;
                    if (sb.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_out: got y=%0d, expected no result", y);
                    end else begin
                        e = sb.pop_front();
                        check("model_y", y, e.y);
                        check("model_sat", sat, e.sat);
                    end
                end
                if (in_valid && in_ready) begin
                    sb.push_back(model(op, a, b));
                    n_acc++;
                    acc_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_y = y;
                prev_sat = sat;
            end
        end
    end

    task automatic send(input logic [1:0] o, input logic signed [16:0] aa,
                        input logic signed [16:0] bb);
        int   n;
        logic took;
        n = 0;
        op = o;
        a = aa;
        b = bb;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            n++;
        end while (!took && n < 50);
        in_valid = 1'b0;
        if (!took) check("send_timeout", 0, 1);
    endtask

    task automatic wait_deliv(input int pre, input string name);
        int n;
        n = 0;
        while (n_deliv == pre && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n_deliv == pre) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s_timeout: got no result, expected one", name);
        end
    endtask

    task automatic directed(input string name, input logic [1:0] o,
                            input logic signed [16:0] aa, input logic signed [16:0] bb,
                            input longint ey, input logic es);
        int pre;
        pre = n_deliv;
        out_ready = 1'b1;
        send(o, aa, bb);
        wait_deliv(pre, name);
        check({name, "_y"}, last_y, ey);
        check({name, "_sat"}, last_sat, es);
        check({name, "_latency"}, deliv_cyc - acc_cyc, 3);
    endtask

    initial begin
        int k;
        int target;
        int pre;
        int n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_out_valid", out_valid, 0);
        check("reset_y", y, 0);
        check("reset_sat", sat, 0);
        check("reset_sat_count", sat_count, 0);
        check("reset_in_ready", in_ready, 1);

        directed("add", 2'b00, 16384, 4096, 32768, 1'b0);
        directed("mul", 2'b10, 40960, -6144, -61440, 1'b0);
        directed("sub", 2'b01, 40960, -6144, 65536, 1'b0);
        directed("sat_pos", 2'b00, 65535, 61440, 131071, 1'b1);
        check("sat_count_1", sat_count, 1);
        directed("sat_neg", 2'b00, -65536, -61440, -131072, 1'b1);
        check("sat_count_2", sat_count, 2);
        directed("round_pos", 2'b10, 1, 2048, 1, 1'b0);
        directed("round_neg", 2'b10, -1, 2048, 0, 1'b0);
        directed("pass", 2'b11, -12345, 777, -12345, 1'b0);

        // Randomized stream with random backpressure.
        k = 0;
        target = n_acc + 48000;
        while (n_acc < target && k < 90000) begin
            in_valid = ($urandom_range(7) != 0);
            out_ready = ($urandom_range(7) != 0);
            op = 2'($urandom);
            a = 17'($urandom);
            b = 17'($urandom);
            if ($urandom_range(3) == 0) begin
                a = a >>> 10;
                b = b >>> 10;
            end
            @(posedge clk);
            #1;
            k++;
        end
        check("stream_accepted", n_acc, target);
        in_valid = 1'b0;
        out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_empty", sb.size(), 0);
        check("no_loss_dup", n_deliv, n_acc);

        // Reset with three beats in flight.
        pre = n_deliv;
        for (int i = 0; i < 3; i++) begin
            op = 2'b00;
            a = 65535;
            b = 17'(i * 1000);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_sat_count", sat_count, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("postrst_in_ready", in_ready, 1);
        repeat (6) @(posedge clk);
        #1;
        check("postrst_no_ghost", n_deliv, pre);
        directed("postrst_add", 2'b00, 16384, 4096, 32768, 1'b0);
        directed("postrst_sat", 2'b00, 65535, 61440, 131071, 1'b1);
        check("postrst_sat_count", sat_count, 1);

        // sat_clr coinciding with a saturated delivery.
        out_ready = 1'b0;
        pre = n_deliv;
        send(2'b01, -65536, 61440);
        n = 0;
        while (!out_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("clr_out_valid", out_valid, 1);
        repeat (2) @(posedge clk);
        #1;
        check("clr_held_sat", sat, 1);
        sat_clr = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        sat_clr = 1'b0;
        check("clr_sat_count", sat_count, 0);
        check("clr_delivered", n_deliv - pre, 1);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fxp_alu_pipe.md
Name: fxp_alu_pipe

Overview:
- Parametrised, pipelined fixed-point arithmetic unit; successor to the separate fixed-width add/subtract/mul blocks.
- Takes two signed operands in independent Q formats (default Q3.14 and Q5.12, 17 bits each) and an op select.
- Aligns binary points and computes add, sub, mul or pass-through.
- Rounds and saturates the result into a parametrised output Q format, behind a valid/ready stream handshake.

Parameters:
- A_W, 17, total width of operand a (signed two's complement).
- A_FRAC, 14, fractional bits of a.
- B_W, 17, total width of operand b (signed).
- B_FRAC, 12, fractional bits of b.
- Y_W, 18, total width of result y (signed).
- Y_FRAC, 14, fractional bits of y.
- CNT_W, 16, width of the saturation event counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset: asynchronous, active-high.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts a beat this cycle.
- op  in  2  00 add, 01 sub (a-b), 10 mul, 11 pass a.
- a  in  A_W  operand a.
- b  in  B_W  operand b.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts the result.
- y  out  Y_W  rounded, saturated result.
- sat  out  1  this result was clipped; qualified by out_valid.
- sat_clr  in  1  synchronous clear of sat_count.
- sat_count  out  CNT_W  number of saturated results delivered; sticks at all-ones.

Behaviour:
- Reset: out_valid=0, y=0, sat=0, sat_count=0, all internal stage valids=0. in_ready=1 from the first cycle after reset.
- Reset asserted mid-operation discards all in-flight beats; no partial result is emitted.
- Pipeline has 3 stages, so latency is 3 cycles from an accepted input to out_valid, with no stall.
  - S1: register op, sign-extend a and b, and align both to F=max(A_FRAC,B_FRAC) by left shift (add/sub/pass only).
  - S2: compute. add/sub use F fractional bits and max(A_W-A_FRAC,B_W-B_FRAC)+F+1 bits, so no internal overflow. mul uses the full A_W+B_W product with A_FRAC+B_FRAC fractional bits, computed from the unaligned operands.
  - S3: convert to Y_FRAC, then saturate, then register y and sat.
- Throughput: 1 beat per cycle.
- Advance: the whole pipeline advances when (!out_valid || out_ready). in_ready equals that term, combinationally.
- Stall: when out_valid && !out_ready, every stage holds and y/sat stay stable.
- Bubbles: a stage with valid=0 may be overwritten even while a later stage stalls; bubble collapse is optional, but the 3-cycle latency is required.
- Acceptance: a beat is accepted iff in_valid && in_ready; a is dropped only when in_ready=0.
- Delivery: a result is delivered iff out_valid && out_ready.
- Rounding (source frac S > Y_FRAC): add 2^(S-Y_FRAC-1), then arithmetic right shift by S-Y_FRAC (round half up, toward +inf).
- Source frac S <= Y_FRAC: left shift by Y_FRAC-S, exact.
- Saturation: clip to [-2^(Y_W-1), 2^(Y_W-1)-1] after rounding, and set sat=1. A rounding carry that overflows also saturates.
- sat_count: increments on each delivered beat with sat=1, and saturates at 2^CNT_W-1.
- sat_clr has priority over an increment in the same cycle; the result is 0.
- op=11 converts a alone; b is ignored.
- Parameter constraints, checked at elaboration: Y_FRAC <= A_FRAC+B_FRAC, and all widths >= 2.

Decomposition:
- Shared package fxp_pkg holds:
  - op encoding constants OP_ADD, OP_SUB, OP_MUL, OP_PASS;
  - a 2-bit op typedef;
  - a constant function computing max for F.
- One sub-module, fxp_round_sat, holds the S3 datapath. Its parameters are IN_W, IN_FRAC, OUT_W and OUT_FRAC; its outputs are y and sat, and it is purely combinational.

Test Plan:
- Add: a=16384 (1.0), b=4096 (1.0), op=00 -> y=32768 (2.0), sat=0, out_valid exactly 3 cycles after acceptance.
- Mul: a=40960 (2.5), b=-6144 (-1.5), op=10 -> y=-61440 (-3.75), sat=0. Sub with the same operands -> y=65536 (4.0).
- Saturate: a=65535, b=61440 (15.0), op=00 -> y=131071, sat=1, sat_count=1. a=-65536, b=-61440 -> y=-131072, sat=1, sat_count=2.
- Rounding: a=1, b=2048, op=10 (product 2^-15) -> y=1. a=-1, b=2048 -> y=0 (half up).
- Backpressure: stream 48000 samples with random in_valid and out_ready. Results must be in order, match a bit-exact model, and have no loss or duplication. y/sat must be stable whenever out_valid && !out_ready.
- Reset: assert rst with 3 beats in flight -> out_valid=0 immediately and sat_count=0. Delivered results resume only from new inputs, 3 cycles after acceptance. sat_clr together with a sat delivery -> sat_count=0.
